// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported SRAM between the instruction-fetch (IM) and data (DM) ports.
// Latency : grant is combinational with the request; read data returns one cycle after the grant.
// Backpressure: DM has fixed priority; IM is stalled (im_ready=0) and is forced through after STARVE_MAX denials.
//
// Ports:
//   clk, rst          - clock (posedge) and asynchronous active-low reset
//   im_req/im_addr    - fetch request, held until im_ready; im_rvalid/im_rdata carry the response
//   dm_req/dm_web/dm_addr/dm_wdata - load/store request (dm_web active-low, 4'hF = read), held until dm_ready
//   dm_rvalid/dm_rdata - load response (stores produce no rvalid)
//   sram_*            - macro interface; sram_do is valid the cycle after the sampling edge
module mem_port_arbiter #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          im_req,
  input  logic [31:0]   im_addr,
  output logic          im_ready,
  output logic          im_rvalid,
  output logic [31:0]   im_rdata,
  input  logic          dm_req,
  input  logic [3:0]    dm_web,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ready,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic [3:0]    sram_web,
  output logic [AW-1:0] sram_a,
  output logic [31:0]   sram_di,
  input  logic [31:0]   sram_do
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IM   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e        rsp_owner;
  logic [CW-1:0] starve_cnt;

  logic force_im;
  logic grant_im;
  logic grant_dm;
  logic dm_is_read;

  // Byte-offset and upper address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr[31:AW+2], im_addr[1:0],
                              dm_addr[31:AW+2], dm_addr[1:0]};

  assign dm_is_read = (dm_web == 4'hF);

  // Grants are qualified with rst so every handshake and SRAM output
  // drops to its idle value the moment reset asserts, not at the next edge.
  assign force_im = im_req & (starve_cnt == CW'(STARVE_MAX));
  assign grant_im = rst & im_req & (~dm_req | force_im);
  assign grant_dm = rst & dm_req & ~grant_im;

  assign im_ready = grant_im;
  assign dm_ready = grant_dm;

  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 4'hF;
    sram_a   = '0;
    sram_di  = '0;
    if (grant_im) begin
      sram_cs = 1'b1;
      sram_oe = 1'b1;
      sram_a  = im_addr[AW+1:2];
    end else if (grant_dm) begin
      sram_cs  = 1'b1;
      sram_oe  = dm_is_read;
      sram_web = dm_web;
      sram_a   = dm_addr[AW+1:2];
      sram_di  = dm_wdata;
    end
  end

  // The SRAM output is shared; consumers qualify it with their own rvalid.
  assign im_rdata  = sram_do;
  assign dm_rdata  = sram_do;
  assign im_rvalid = rst & (rsp_owner == OWN_IM);
  assign dm_rvalid = rst & (rsp_owner == OWN_DM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_owner  <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (grant_im)
        rsp_owner <= OWN_IM;
      else if (grant_dm && dm_is_read)
        rsp_owner <= OWN_DM;
      else
        rsp_owner <= OWN_NONE;

      // Counts consecutive denied IM cycles; any IM win or a dropped request clears it.
      if (im_req && !grant_im) begin
        if (starve_cnt != CW'(STARVE_MAX))
          starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule
